invader_game_ctrl: RTL
======================

Name: invader_game_ctrl

Overview:
- Frame-synchronous game sequencer and collision scoreboard for the VGA sprite pipeline.
- Samples the per-pixel sprite active strobes from the alien, player/missile and barrier generators.
- Detects missile/alien and missile/barrier overlaps, and owns the 15 alien-alive bits, score and game state (ATTRACT/PLAY/WIN/LOSE).
- Drives the compositor's alive masks, the win/lose screen selects and per-missile retire pulses.

Parameters:
- N_ALIEN, 15, alien count; bits 0-4 = row A, 5-9 = row B, 10-14 = row C.
- N_MISSLE, 8, missile count.
- PTS_A, 30, points per row-A kill.
- PTS_B, 20, points per row-B kill.
- PTS_C, 10, points per row-C kill.
- SCORE_MAX, 9999, score saturation value.
- HOLD_FRAMES, 180, frames the WIN/LOSE screen is held before returning to ATTRACT.

Ports:
- vga_clk_i  in  1  pixel clock
- vga_rst_i  in  1  asynchronous, active-low reset
- video_on  in  1  visible-area qualifier from dtg
- frame_tick  in  1  one-cycle pulse on the first blanking pixel after the last visible line
- alien_active  in  N_ALIEN  per-pixel alien strobes
- missle_active  in  N_MISSLE  per-pixel missile strobes
- barrier_active  in  4  per-pixel barrier strobes
- landed  in  1  OR of loserA/B/C (aliens reached bottom)
- start_btn  in  1  debounced start level
- alien_alive  out  N_ALIEN  alive mask to compositor
- missle_retire  out  N_MISSLE  one-cycle retire pulse per missile
- game_state  out  2  00 ATTRACT, 01 PLAY, 10 WIN, 11 LOSE
- winner  out  1  state==WIN
- loser  out  1  state==LOSE
- score  out  14  binary score

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - state=ATTRACT, alien_alive=all ones, score=0, missle_retire=0.
  - Pending-kill and pending-retire accumulators cleared; hold counter=0.
- Collision detect (PLAY only, video_on=1), per cycle:
  - hit_m = |missle_active.
  - For each j: pend_kill[j] |= alien_active[j] & alien_alive[j] & hit_m.
  - For each k: pend_ret[k] |= missle_active[k] & ((|(alien_active & alien_alive)) | (|barrier_active)).
  - Several aliens overlapping at one pixel are all killed.
  - Samples while video_on=0 are ignored.
- Commit, on the frame_tick cycle (registered, visible the cycle after):
  - alien_alive &= ~pend_kill.
  - missle_retire = pend_ret for exactly one cycle.
  - score += PTS_A*popcount(kill A) + PTS_B*popcount(kill B) + PTS_C*popcount(kill C), saturating at SCORE_MAX; add width 14 bits, compare before write.
  - Accumulators cleared in the same cycle.
  - A strobe coincident with frame_tick is accumulated into the next frame.
- Alive mask never changes mid-frame, so no tearing.
- State machine (transitions evaluated only on frame_tick):
  - ATTRACT: start_btn=1 -> PLAY; alien_alive set to all ones, score cleared.
  - PLAY: post-commit alive==0 -> WIN. Otherwise landed==1 (sticky-latched within the frame) -> LOSE. WIN takes priority when both happen in the same frame.
  - WIN/LOSE: hold counter counts frames; at HOLD_FRAMES-1 -> ATTRACT and counter cleared. start_btn is ignored.
- landed and start_btn outside their listed states are ignored; the landed latch clears on every frame_tick.
- Outputs are registered; winner/loser decode from the state register.
- Reset asserted mid-frame discards all pending accumulators.

Decomposition:
- Package invader_pkg:
  - game_state_t enum (ATTRACT, PLAY, WIN, LOSE).
  - Constants N_ALIEN, N_MISSLE, row index ranges, point values.
- Sub-module invader_score_acc: three 5-bit popcounts, weighted sum, saturating 14-bit adder with enable.

Test Plan:
- Reset low mid-PLAY -> state=00, alive=0x7FFF, score=0, retire=0 within the same cycle as the reset assertion.
- ATTRACT, start_btn=1, frame_tick -> state=01, alive=0x7FFF, score=0.
- PLAY, one pixel with alien_active[6]=1 and missle_active[2]=1:
  - before frame_tick -> alive unchanged.
  - cycle after frame_tick -> alive=0x7FBF, retire=0x04 for 1 cycle, score=20.
- Killed alien 6 strobed again with missile 2 next frame -> no kill, retire=0, score unchanged.
- Barrier 1 with missile 5 -> retire=0x20, score unchanged.
- Last alien (index 0, row A) killed in the same frame that landed=1 -> WIN, score +30.
- After HOLD_FRAMES frame_ticks -> ATTRACT.
- score=9990 plus a row-A kill -> score=9999.
- landed=1 in PLAY with aliens remaining -> LOSE.
- start_btn held during LOSE is ignored; after 180 ticks -> ATTRACT.

Source files
------------

// File: rtl/invader_pkg.sv
// Shared types and constants for the invader game sequencer.
package invader_pkg;

    localparam int unsigned N_ALIEN   = 15;
    localparam int unsigned N_MISSLE  = 8;
    localparam int unsigned SCORE_W   = 14;

    // Alien rows: bits 0-4 row A, 5-9 row B, 10-14 row C.
    localparam int unsigned ROW_A_LO  = 0;
    localparam int unsigned ROW_A_HI  = 4;
    localparam int unsigned ROW_B_LO  = 5;
    localparam int unsigned ROW_B_HI  = 9;
    localparam int unsigned ROW_C_LO  = 10;
    localparam int unsigned ROW_C_HI  = 14;

    localparam int unsigned PTS_A     = 30;
    localparam int unsigned PTS_B     = 20;
    localparam int unsigned PTS_C     = 10;

    localparam int unsigned DEF_SCORE_MAX   = 9999;
    localparam int unsigned DEF_HOLD_FRAMES = 180;

    typedef enum logic [1:0] {
        ATTRACT = 2'b00,
        PLAY    = 2'b01,
        WIN     = 2'b10,
        LOSE    = 2'b11
    } game_state_t;

    function automatic logic [2:0] popcount5(input logic [4:0] v);
        logic [2:0] n;
        n = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            n = n + 3'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/invader_score_acc.sv
// Weighted kill scoring with a saturating score adder.
module invader_score_acc
    import invader_pkg::*;
#(
    parameter int unsigned SCORE_MAX = DEF_SCORE_MAX
) (
    input  logic               en,
    input  logic [N_ALIEN-1:0] kill,
    input  logic [SCORE_W-1:0] score_cur,
    output logic [SCORE_W-1:0] score_nxt
);

    logic [2:0]         cnt_a;
    logic [2:0]         cnt_b;
    logic [2:0]         cnt_c;
    logic [SCORE_W-1:0] pts;
    logic [SCORE_W-1:0] sum;

    // Count kills per row, weight them, and clamp the running score.
    always_comb begin
        cnt_a = popcount5(kill[ROW_A_HI:ROW_A_LO]);
        cnt_b = popcount5(kill[ROW_B_HI:ROW_B_LO]);
        cnt_c = popcount5(kill[ROW_C_HI:ROW_C_LO]);
        pts   = SCORE_W'(cnt_a) * SCORE_W'(PTS_A)
              + SCORE_W'(cnt_b) * SCORE_W'(PTS_B)
              + SCORE_W'(cnt_c) * SCORE_W'(PTS_C);
        sum   = score_cur + pts;
        if (!en) begin
            score_nxt = score_cur;
        end else if (sum > SCORE_W'(SCORE_MAX)) begin
            score_nxt = SCORE_W'(SCORE_MAX);
        end else begin
            score_nxt = sum;
        end
    end

endmodule

// File: rtl/invader_game_ctrl.sv
// Frame-synchronous game sequencer and collision scoreboard.
module invader_game_ctrl
    import invader_pkg::*;
#(
    parameter int unsigned SCORE_MAX   = DEF_SCORE_MAX,
    parameter int unsigned HOLD_FRAMES = DEF_HOLD_FRAMES
) (
    input  logic                vga_clk_i,
    input  logic                vga_rst_i,
    input  logic                video_on,
    input  logic                frame_tick,
    input  logic [N_ALIEN-1:0]  alien_active,
    input  logic [N_MISSLE-1:0] missle_active,
    input  logic [3:0]          barrier_active,
    input  logic                landed,
    input  logic                start_btn,
    output logic [N_ALIEN-1:0]  alien_alive,
    output logic [N_MISSLE-1:0] missle_retire,
    output logic [1:0]          game_state,
    output logic                winner,
    output logic                loser,
    output logic [SCORE_W-1:0]  score
);

    localparam int unsigned HOLD_W = (HOLD_FRAMES > 2) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

    game_state_t         state;
    logic [N_ALIEN-1:0]  pend_kill;
    logic [N_MISSLE-1:0] pend_ret;
    logic                landed_lat;
    logic [HOLD_W-1:0]   hold_cnt;

    logic                sample;
    logic [N_ALIEN-1:0]  alive_post;
    logic [N_ALIEN-1:0]  alive_eff;
    logic [N_ALIEN-1:0]  kill_now;
    logic [N_MISSLE-1:0] ret_now;
    logic                landed_seen;
    logic                score_en;
    logic [SCORE_W-1:0]  score_nxt;

    // Per-pixel overlap detection; on the commit cycle new samples are masked
    // with the post-commit alive set so an alien dying now cannot score twice.
    always_comb begin
        sample      = (state == PLAY) && video_on;
        alive_post  = alien_alive & ~pend_kill;
        alive_eff   = frame_tick ? alive_post : alien_alive;
        kill_now    = '0;
        ret_now     = '0;
        if (sample && (|missle_active)) begin
            kill_now = alien_active & alive_eff;
        end
        if (sample && ((|(alien_active & alive_eff)) || (|barrier_active))) begin
            ret_now = missle_active;
        end
        landed_seen = landed_lat | landed;
        score_en    = (state == PLAY) && frame_tick;
    end

    invader_score_acc #(
        .SCORE_MAX (SCORE_MAX)
    ) u_score_acc (
        .en        (score_en),
        .kill      (pend_kill),
        .score_cur (score),
        .score_nxt (score_nxt)
    );

    // Game FSM plus frame accumulators and commit of alive/score/retire.
    always_ff @(posedge vga_clk_i or negedge vga_rst_i) begin
        if (!vga_rst_i) begin
            state         <= ATTRACT;
            alien_alive   <= '1;
            score         <= '0;
            missle_retire <= '0;
            pend_kill     <= '0;
            pend_ret      <= '0;
            landed_lat    <= 1'b0;
            hold_cnt      <= '0;
        end else begin
            missle_retire <= '0;
            case (state)
                ATTRACT: begin
                    pend_kill  <= '0;
                    pend_ret   <= '0;
                    landed_lat <= 1'b0;
                    hold_cnt   <= '0;
                    if (frame_tick && start_btn) begin
                        state       <= PLAY;
                        alien_alive <= '1;
                        score       <= '0;
                    end
                end
                PLAY: begin
                    if (frame_tick) begin
                        alien_alive   <= alive_post;
                        missle_retire <= pend_ret;
                        score         <= score_nxt;
                        landed_lat    <= 1'b0;
                        hold_cnt      <= '0;
                        if (alive_post == '0) begin
                            state     <= WIN;
                            pend_kill <= '0;
                            pend_ret  <= '0;
                        end else if (landed_seen) begin
                            state     <= LOSE;
                            pend_kill <= '0;
                            pend_ret  <= '0;
                        end else begin
                            pend_kill <= kill_now;
                            pend_ret  <= ret_now;
                        end
                    end else begin
                        pend_kill  <= pend_kill | kill_now;
                        pend_ret   <= pend_ret | ret_now;
                        landed_lat <= landed_seen;
                    end
                end
                WIN, LOSE: begin
                    if (frame_tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            state    <= ATTRACT;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ATTRACT;
            endcase
        end
    end

    assign game_state = state;
    assign winner     = (state == WIN);
    assign loser      = (state == LOSE);

endmodule
